// File: rtl/fifo_pkg.sv
// Shared widths and frame type for the frame-assembling FIFO.
package fifo_pkg;

    localparam int WORD_W          = 16;
    localparam int WORDS_PER_FRAME = 8;
    localparam int SLOT_SEL_W      = 3;
    localparam int FRAME_W         = WORD_W * WORDS_PER_FRAME;

    typedef logic [FRAME_W-1:0] frame_t;

    // Bit offset of a 16-bit slot inside a frame.
    function automatic int slot_lsb(input logic [SLOT_SEL_W-1:0] slot);
        return int'(slot) * WORD_W;
    endfunction

endpackage

// File: rtl/frame_store.sv
// Frame memory: 16-bit slot writes, whole-entry clears, and a read port that
// shows each entry as it will be after this cycle's writes.
module frame_store
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  sample_clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [SLOT_SEL_W-1:0] wr_slot,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic                  clr_en,
    input  logic [ADDR_W-1:0]     clr_addr,
    input  logic [ADDR_W-1:0]     rd_addr,
    output frame_t                rd_frame
);

    frame_t mem [DEPTH];

    // A clear to the same entry overrides the slot write (dropped frame).
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_addr][slot_lsb(wr_slot) +: WORD_W] <= wr_data;
            end
            if (clr_en) begin
                mem[clr_addr] <= '0;
            end
        end
    end

    always_comb begin
        rd_frame = mem[rd_addr];
        if (wr_en && (rd_addr == wr_addr)) begin
            rd_frame[slot_lsb(wr_slot) +: WORD_W] = wr_data;
        end
        if (clr_en && (rd_addr == clr_addr)) begin
            rd_frame = '0;
        end
    end

endmodule

// File: rtl/dual_clock_fifo.sv
// Assembles 16-bit samples into 128-bit frames and queues committed frames
// for the reader, head frame presented look-ahead. Single clock despite the name.
module dual_clock_fifo
    import fifo_pkg::*;
#(
    parameter int FRAME_DEPTH = 16
) (
    input  logic                  sample_clk,
    input  logic                  reset,
    input  logic [WORD_W-1:0]     data_in,
    input  logic                  done,
    input  logic                  last_word,
    input  logic [SLOT_SEL_W-1:0] atmchsel,
    input  logic [3:0]            threshold,
    output logic                  fifo_ready,
    input  logic                  frame_pop,
    output frame_t                frame_data_out,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FRAME_DEPTH);
    localparam int CMP_W = (PTR_W > 4) ? PTR_W : 4;
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(FRAME_DEPTH - 1);

    logic [PTR_W-1:0] write_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] count_next;
    logic [PTR_W-1:0] write_ptr_next;
    logic [PTR_W-1:0] read_ptr_next;
    logic             commit;
    logic             commit_ok;
    logic             drop;
    logic             pop_ok;
    logic             clr_en;
    logic [PTR_W-1:0] clr_addr;
    logic [3:0]       eff_threshold;
    frame_t           head_next;

    // Reader handshake: frame_pop consumes the head when count>0 and is ignored
    // otherwise; a same-cycle pop frees the slot a full-FIFO commit needs.
    assign pop_ok    = frame_pop && (count != '0);
    assign commit    = done && last_word;
    assign commit_ok = commit && ((count != FULL_COUNT) || pop_ok);
    assign drop      = commit && !commit_ok;

    assign write_ptr_next = commit_ok ? write_ptr + PTR_ONE : write_ptr;
    assign read_ptr_next  = pop_ok ? read_ptr + PTR_ONE : read_ptr;

    always_comb begin
        count_next = count;
        unique case ({commit_ok, pop_ok})
            2'b10:   count_next = count + PTR_ONE;
            2'b01:   count_next = count - PTR_ONE;
            default: count_next = count;
        endcase
    end

    // Commit pre-zeroes the next open frame; a drop wipes the open frame.
    assign clr_en   = commit_ok || drop;
    assign clr_addr = drop ? write_ptr : write_ptr + PTR_ONE;

    assign eff_threshold = (threshold == 4'd0) ? 4'd1 : threshold;

    frame_store #(
        .DEPTH  (FRAME_DEPTH),
        .ADDR_W (PTR_W)
    ) u_frame_store (
        .sample_clk (sample_clk),
        .reset      (reset),
        .wr_en      (done),
        .wr_addr    (write_ptr),
        .wr_slot    (atmchsel),
        .wr_data    (data_in),
        .clr_en     (clr_en),
        .clr_addr   (clr_addr),
        .rd_addr    (read_ptr_next),
        .rd_frame   (head_next)
    );

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            write_ptr      <= '0;
            read_ptr       <= '0;
            count          <= '0;
            fifo_ready     <= 1'b0;
            frame_data_out <= '0;
            overflow       <= 1'b0;
        end else begin
            write_ptr      <= write_ptr_next;
            read_ptr       <= read_ptr_next;
            count          <= count_next;
            fifo_ready     <= CMP_W'(count_next) >= CMP_W'(eff_threshold);
            frame_data_out <= (count_next != '0) ? head_next : '0;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_clock_fifo.sv
// Directed bench for dual_clock_fifo: vector table plus corner-case sequences.
module tb_dual_clock_fifo;
    import fifo_pkg::*;

    logic              sample_clk;
    logic              reset;
    logic [WORD_W-1:0] data_in;
    logic              done;
    logic              last_word;
    logic [2:0]        atmchsel;
    logic [3:0]        threshold;
    logic              fifo_ready;
    logic              frame_pop;
    frame_t            frame_data_out;
    logic              overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [FRAME_W-1:0] exp_q[$];

    dual_clock_fifo #(.FRAME_DEPTH(16)) dut (
        .sample_clk     (sample_clk),
        .reset          (reset),
        .data_in        (data_in),
        .done           (done),
        .last_word      (last_word),
        .atmchsel       (atmchsel),
        .threshold      (threshold),
        .fifo_ready     (fifo_ready),
        .frame_pop      (frame_pop),
        .frame_data_out (frame_data_out),
        .overflow       (overflow)
    );

    // clock / reset
    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    typedef struct {
        logic        rst;
        logic        dn;
        logic        lst;
        logic [2:0]  slot;
        logic [15:0] dat;
        logic        pop;
        logic [3:0]  thr;
        logic        exp_ready;
        frame_t      exp_out;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic dn, input logic lst,
                                input logic [2:0] slot, input logic [15:0] dat,
                                input logic pop, input logic [3:0] thr,
                                input logic exp_ready, input frame_t exp_out);
        vec_t v;
        v.rst = rst; v.dn = dn; v.lst = lst; v.slot = slot; v.dat = dat;
        v.pop = pop; v.thr = thr; v.exp_ready = exp_ready; v.exp_out = exp_out;
        v.exp_ovf = 1'b0;
        return v;
    endfunction

    function automatic frame_t one_slot(input logic [2:0] slot, input logic [15:0] dat);
        frame_t f;
        f = '0;
        f[slot_lsb(slot) +: WORD_W] = dat;
        return f;
    endfunction

    task automatic check(input string name, input logic [FRAME_W-1:0] act,
                         input logic [FRAME_W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs, sample 1 time unit after the edge
    task automatic cycle(input logic rst, input logic dn, input logic lst,
                         input logic [2:0] slot, input logic [15:0] dat,
                         input logic pop);
        reset = rst; done = dn; last_word = lst; atmchsel = slot;
        data_in = dat; frame_pop = pop;
        @(posedge sample_clk);
        #1;
        reset = 1'b0; done = 1'b0; last_word = 1'b0; frame_pop = 1'b0;
    endtask

    localparam frame_t ALL_F   = {8{16'hFFFF}};
    localparam frame_t FRAME_A = 128'h0000_0000_BBBB_0000_0000_AAAA_0000_0000;
    localparam frame_t FRAME_B = 128'h7777_0000_0000_0000_3333_0000_0000_1111;

    initial begin
        frame_t exp_head;
        reset = 1'b0; done = 1'b0; last_word = 1'b0; atmchsel = '0;
        data_in = '0; frame_pop = 1'b0; threshold = 4'd1;
        repeat (2) @(posedge sample_clk);
        #1;

        // full frame of 0xFFFF, then pop
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 0, '0));
        for (int i = 0; i < 7; i++) begin
            vecs.push_back(mk(0, 1, 0, 3'(i), 16'hFFFF, 0, 1, 0, '0));
        end
        vecs.push_back(mk(0, 1, 1, 7, 16'hFFFF, 0, 1, 1, ALL_F));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, '0));
        // sparse frames A and B
        vecs.push_back(mk(0, 1, 0, 2, 16'hAAAA, 0, 1, 0, '0));
        vecs.push_back(mk(0, 1, 1, 5, 16'hBBBB, 0, 1, 1, FRAME_A));
        vecs.push_back(mk(0, 1, 0, 0, 16'h1111, 0, 1, 1, FRAME_A));
        vecs.push_back(mk(0, 1, 0, 3, 16'h9999, 0, 1, 1, FRAME_A));
        vecs.push_back(mk(0, 1, 0, 3, 16'h3333, 0, 1, 1, FRAME_A));
        vecs.push_back(mk(0, 1, 1, 7, 16'h7777, 0, 1, 1, FRAME_A));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, FRAME_B));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, '0));
        // threshold = 3
        vecs.push_back(mk(0, 1, 1, 0, 16'hC001, 0, 3, 0, one_slot(0, 16'hC001)));
        vecs.push_back(mk(0, 1, 1, 0, 16'hC002, 0, 3, 0, one_slot(0, 16'hC001)));
        vecs.push_back(mk(0, 1, 1, 0, 16'hC003, 0, 3, 1, one_slot(0, 16'hC001)));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 3, 0, one_slot(0, 16'hC002)));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 3, 0, one_slot(0, 16'hC003)));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 3, 0, '0));
        // threshold = 0 behaves as 1; pop on empty is ignored
        vecs.push_back(mk(0, 1, 1, 1, 16'h5555, 0, 0, 1, one_slot(1, 16'h5555)));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, '0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, '0));
        vecs.push_back(mk(0, 1, 1, 6, 16'h6666, 0, 0, 1, one_slot(6, 16'h6666)));

        foreach (vecs[i]) begin
            threshold = vecs[i].thr;
            cycle(vecs[i].rst, vecs[i].dn, vecs[i].lst, vecs[i].slot, vecs[i].dat, vecs[i].pop);
            check($sformatf("vec%0d.ready", i), 128'(fifo_ready), 128'(vecs[i].exp_ready));
            check($sformatf("vec%0d.out", i), frame_data_out, vecs[i].exp_out);
            check($sformatf("vec%0d.ovf", i), 128'(overflow), 128'(vecs[i].exp_ovf));
        end

        // overflow: 16 commits with no pops, 16th dropped
        threshold = 4'd15;
        cycle(1, 0, 0, 0, 16'h0000, 0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 1, 3'(i % 8), 16'hA000 + 16'(i), 0);
            if (i < 15) exp_q.push_back(one_slot(3'(i % 8), 16'hA000 + 16'(i)));
            if (i == 14) begin
                check("ovf.ready_at_15", 128'(fifo_ready), 128'(1));
                check("ovf.no_ovf_at_15", 128'(overflow), 128'(0));
            end
        end
        check("ovf.count", 128'(dut.count), 128'(15));
        check("ovf.flag", 128'(overflow), 128'(1));
        for (int i = 0; i < 15; i++) begin
            exp_head = exp_q.pop_front();
            check($sformatf("ovf.drain%0d", i), frame_data_out, exp_head);
            cycle(0, 0, 0, 0, 16'h0000, 1);
        end
        check("ovf.final_head", frame_data_out, '0);
        check("ovf.final_ready", 128'(fifo_ready), 128'(0));
        check("ovf.sticky", 128'(overflow), 128'(1));
        threshold = 4'd1;
        cycle(0, 1, 1, 3, 16'h0033, 0);
        check("ovf.dropped_cleared", frame_data_out, one_slot(3, 16'h0033));

        // full FIFO with simultaneous commit and pop
        cycle(1, 0, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 15; i++) begin
            cycle(0, 1, 1, 0, 16'hB000 + 16'(i), 0);
        end
        check("sim.count_full", 128'(dut.count), 128'(15));
        cycle(0, 1, 1, 2, 16'hBEEF, 1);
        check("sim.count", 128'(dut.count), 128'(15));
        check("sim.ovf", 128'(overflow), 128'(0));
        check("sim.head", frame_data_out, one_slot(0, 16'hB001));
        for (int i = 0; i < 14; i++) begin
            cycle(0, 0, 0, 0, 16'h0000, 1);
        end
        check("sim.tail", frame_data_out, one_slot(2, 16'hBEEF));

        // reset in mid-frame
        cycle(0, 1, 0, 0, 16'hDEAD, 0);
        cycle(0, 1, 0, 2, 16'hBEEF, 0);
        cycle(0, 1, 0, 4, 16'hCAFE, 0);
        cycle(1, 0, 0, 0, 16'h0000, 0);
        check("rst.head_cleared", frame_data_out, '0);
        cycle(0, 1, 1, 1, 16'h1234, 0);
        check("rst.head", frame_data_out, 128'h0000_0000_0000_0000_0000_0000_1234_0000);
        check("rst.count", 128'(dut.count), 128'(1));
        check("rst.ovf", 128'(overflow), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
